// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_PUSH = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] pc_plus4;
  } fetch_elem_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_protocol_checker.sv
// Flags instruction-memory responses that arrive when no request is outstanding.
module fetch_protocol_checker (
  input logic clk_i,
  input logic rst_i,
  input logic imem_valid_i,
  input logic expect_resp_i
);

  // A response is legal only in S_WAIT or S_DROP.
  a_no_stray_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    (imem_valid_i |-> expect_resp_i));

endmodule

// File: rtl/fetch_stat_counters.sv
// Free-running push/stall counters for the fetch stage (used only with FETCH_STATS_EN).
module fetch_stat_counters (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_ok_i,
  input  logic        push_stall_i,
  output logic [31:0] fetched_o,
  output logic [31:0] stalls_o
);

  logic [31:0] fetched_q;
  logic [31:0] stalls_q;

  // Counters wrap naturally modulo 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetched_q <= 32'd0;
      stalls_q  <= 32'd0;
    end else begin
      if (push_ok_i) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (push_stall_i) begin
        stalls_q <= stalls_q + 32'd1;
      end
    end
  end

  assign fetched_o = fetched_q;
  assign stalls_o  = stalls_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem request, element packing and FIFO push.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_BITS      = 32,
  parameter int                    INSTR_BITS     = 32,
  parameter int                    ELEM_SIZE_BITS = 96,
  parameter logic [ADDR_BITS-1:0]  RESET_PC       = DEFAULT_RESET_PC
) (
  input  logic                      CLK,
  input  logic                      RESET,
  output logic                      imem_req,
  output logic [ADDR_BITS-1:0]      imem_addr,
  input  logic [INSTR_BITS-1:0]     imem_data,
  input  logic                      imem_valid,
  output logic                      pushing,
  output logic [ELEM_SIZE_BITS-1:0] out_data,
  input  logic                      push_must_wait,
  input  logic                      redirect,
  input  logic [ADDR_BITS-1:0]      redirect_pc,
  input  logic                      stop_fetch
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]               stat_fetched,
  output logic [31:0]               stat_stalls
`endif
);

  localparam logic [ADDR_BITS-1:0] PC_STEP = ADDR_BITS'(4);

  fetch_state_t          state_q, state_d;
  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  fetch_elem_t           elem_q, elem_d;
  logic                  imem_req_s;
  logic                  pushing_s;

  // State, PC and element registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      elem_q  <= '{instr: 32'd0, addr: 32'd0, pc_plus4: 32'd0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      elem_q  <= elem_d;
    end
  end

  // Next-state logic; redirect overrides everything else in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    elem_d     = elem_q;
    imem_req_s = 1'b0;
    pushing_s  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d    = word_align(redirect_pc);
          state_d = S_REQ;
        end else if (!stop_fetch) begin
          imem_req_s = 1'b1;
          state_d    = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = word_align(redirect_pc);
          state_d = imem_valid ? S_REQ : S_DROP;
        end else if (imem_valid) begin
          elem_d  = '{instr: imem_data, addr: pc_q, pc_plus4: pc_q + PC_STEP};
          state_d = S_PUSH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_PUSH: begin
        if (redirect) begin
          pc_d    = word_align(redirect_pc);
          state_d = S_REQ;
        end else if (!push_must_wait) begin
          pushing_s = 1'b1;
          pc_d      = pc_q + PC_STEP;
          state_d   = S_REQ;
        end else begin
          pushing_s = 1'b1;
          state_d   = S_PUSH;
        end
      end
      S_DROP: begin
        // The wrong-path response must still be consumed before refetching.
        if (redirect) begin
          pc_d = word_align(redirect_pc);
        end else begin
          pc_d = pc_q;
        end
        if (imem_valid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign imem_req  = imem_req_s & ~RESET;
  assign imem_addr = RESET ? {ADDR_BITS{1'b0}} : pc_q;
  assign pushing   = pushing_s & ~RESET;
  assign out_data  = RESET ? {ELEM_SIZE_BITS{1'b0}} : elem_q;

  fetch_protocol_checker u_checker (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .imem_valid_i  (imem_valid),
    .expect_resp_i ((state_q == S_WAIT) || (state_q == S_DROP))
  );

`ifdef FETCH_STATS_EN
  fetch_stat_counters u_stats (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .push_ok_i    (pushing_s & ~push_must_wait),
    .push_stall_i (pushing_s & push_must_wait),
    .fetched_o    (stat_fetched),
    .stalls_o     (stat_stalls)
  );
`endif

endmodule
